// File: rtl/mux_arb_n_pkg.sv
// Shared constants for the N-channel selector/arbiter.
// Optional feature macro: MUX_ARB_N_LOCK_EN (adds the round-robin lock input).
package mux_arb_n_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_N     = 4;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin grant search starting after ptr, with an optional lock that pins the grant to ptr.
// Optional feature macro: MUX_ARB_N_LOCK_EN.
module rr_arbiter_n
    import mux_arb_n_pkg::*;
#(
    parameter  int unsigned N     = DEFAULT_N,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     in_valid,
    input  logic [SEL_W-1:0] ptr,
`ifdef MUX_ARB_N_LOCK_EN
    input  logic             lock_active,
`endif
    output logic [SEL_W-1:0] grant,
    output logic             grant_v
);

    // First valid channel at ptr+1, ptr+2, ... wrapping modulo N; ptr itself is checked last.
    always_comb begin
        logic [SEL_W-1:0] idx;
        grant   = '0;
        grant_v = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = SEL_W'((32'(ptr) + k) % N);
            if (!grant_v && in_valid[idx]) begin
                grant_v = 1'b1;
                grant   = idx;
            end
        end
`ifdef MUX_ARB_N_LOCK_EN
        // ptr always names the last granted channel, so a held lock simply re-grants it.
        if (lock_active) begin
            grant   = ptr;
            grant_v = in_valid[ptr];
        end
`endif
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel valid/ready selector with explicit-select or round-robin grant and a
// single-entry registered output stage.
// Optional feature macro: MUX_ARB_N_LOCK_EN (adds lock input for round-robin mode).
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    parameter  int unsigned N     = DEFAULT_N,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
`ifdef MUX_ARB_N_LOCK_EN
    input  logic               lock,
`endif
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src
);

    localparam int unsigned NP = 1 << SEL_W;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic [SEL_W-1:0]   out_src_q,   out_src_d;
    logic [SEL_W-1:0]   ptr_q,       ptr_d;

    logic [NP-1:0]      valid_pad;
    logic [SEL_W-1:0]   rr_grant;
    logic               rr_grant_v;
    logic [SEL_W-1:0]   grant;
    logic               grant_v;
    logic               load;

`ifdef MUX_ARB_N_LOCK_EN
    logic               lock_q, lock_d;
    logic               lock_active;

    // Lock only applies in round-robin mode and only while the input stays high.
    assign lock_active = lock_q && lock && (mode == MODE_RR);
`endif

    assign valid_pad = NP'(in_valid);

    rr_arbiter_n #(
        .N           (N)
    ) u_arb (
        .in_valid    (in_valid),
        .ptr         (ptr_q),
`ifdef MUX_ARB_N_LOCK_EN
        .lock_active (lock_active),
`endif
        .grant       (rr_grant),
        .grant_v     (rr_grant_v)
    );

    // Grant selection, load decision and per-channel ready.
    always_comb begin
        grant    = '0;
        grant_v  = 1'b0;
        in_ready = '0;
        if (mode == MODE_RR) begin
            grant   = rr_grant;
            grant_v = rr_grant_v;
        end else begin
            grant   = sel;
            grant_v = (32'(sel) < N) && valid_pad[sel];
        end
        // Nothing is accepted while reset is asserted, since the output register is held clear.
        load = rst_n && grant_v && (!out_valid_q || out_ready);
        if (load) begin
            in_ready[grant] = 1'b1;
        end
    end

    // Next-state for output register, pointer and lock flag.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
`ifdef MUX_ARB_N_LOCK_EN
        lock_d      = lock_q;
        if (!lock || mode != MODE_RR) begin
            lock_d = 1'b0;
        end else if (load) begin
            lock_d = 1'b1;
        end
`endif
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[32'(grant) * WIDTH +: WIDTH];
            out_src_d   = grant;
            ptr_d       = grant;
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; ptr resets to N-1 so channel 0 wins the first round-robin search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= SEL_W'(N - 1);
`ifdef MUX_ARB_N_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
`ifdef MUX_ARB_N_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed self-checking bench for mux_arb_n (N=4 main instance, N=3 instance for out-of-range select).
module tb_mux_arb_n;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst_n;

    logic          mode;
    logic [1:0]    sel;
    logic          lock;
    logic [3:0]    in_valid;
    logic [3:0]    in_ready;
    logic [4*W-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    out_src;

    logic          mode3;
    logic [1:0]    sel3;
    logic [2:0]    in_valid3;
    logic [2:0]    in_ready3;
    logic [3*W-1:0] in_data3;
    logic          out_valid3;
    logic          out_ready3;
    logic [W-1:0]  out_data3;
    logic [1:0]    out_src3;

    int n_checks;
    int n_fail;

    mux_arb_n #(.WIDTH(W), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
`ifdef MUX_ARB_N_LOCK_EN
        .lock      (lock),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    mux_arb_n #(.WIDTH(W), .N(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode3),
        .sel       (sel3),
`ifdef MUX_ARB_N_LOCK_EN
        .lock      (1'b0),
`endif
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_data   (in_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (out_data3),
        .out_src   (out_src3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_rdy;
        n_checks = 0;
        n_fail   = 0;

        // Reset with random inputs on both instances.
        rst_n      = 1'b0;
        mode       = 1'($urandom);
        sel        = 2'($urandom);
        lock       = 1'($urandom);
        in_valid   = 4'b1111;
        in_data    = {$urandom, $urandom, $urandom, $urandom};
        out_ready  = 1'($urandom);
        mode3      = 1'($urandom);
        sel3       = 2'($urandom);
        in_valid3  = 3'b111;
        in_data3   = {$urandom, $urandom, $urandom};
        out_ready3 = 1'($urandom);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);
        chk("rst_in_ready_late", 32'(in_ready), 32'h0);
        chk("rst_out_valid3", 32'(out_valid3), 32'h0);

        mode = 1'b0; sel = 2'd0; lock = 1'b0; in_valid = '0; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = '0; out_ready3 = 1'b1;
        rst_n = 1'b1;
        tick();

        // Mode 0 explicit select of channel 2.
        in_data          = '0;
        in_data[2*W +: W] = 32'hDEAD_BEEF;
        in_data[1*W +: W] = 32'h1111_1111;
        sel      = 2'd2;
        in_valid = 4'b0100;
        #1;
        chk("m0_in_ready", 32'(in_ready), 32'h4);
        tick();
        chk("m0_out_valid", 32'(out_valid), 32'h1);
        chk("m0_out_data", out_data, 32'hDEAD_BEEF);
        chk("m0_out_src", 32'(out_src), 32'h2);
        in_valid = '0;
        tick();
        chk("m0_drain_valid", 32'(out_valid), 32'h0);
        chk("m0_drain_data_hold", out_data, 32'hDEAD_BEEF);

        // Mode 0 with sel beyond N-1 on the 3-channel instance.
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        in_data3  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        #1;
        chk("oor_in_ready", 32'(in_ready3), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("oor_out_valid", 32'(out_valid3), 32'h0);
        end
        in_valid3 = '0;

        // Round-robin fairness with all channels valid.
        do_reset();
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = 32'hA000_0000 + 32'(i);
        mode      = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            chk("rr_in_ready", 32'(in_ready), 32'(exp_rdy));
            tick();
            chk("rr_out_valid", 32'(out_valid), 32'h1);
            chk("rr_out_src", 32'(out_src), 32'(k % 4));
            chk("rr_out_data", out_data, 32'hA000_0000 + 32'(k % 4));
        end

        // Backpressure after the first load.
        do_reset();
        tick();
        chk("bp_first_src", 32'(out_src), 32'h0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_src", 32'(out_src), 32'h0);
            chk("bp_out_data", out_data, 32'hA000_0000);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_in_ready", 32'(in_ready), 32'h2);
        tick();
        chk("bp_rel_src1", 32'(out_src), 32'h1);
        chk("bp_rel_data1", out_data, 32'hA000_0001);
        #1;
        chk("bp_rel_in_ready2", 32'(in_ready), 32'h4);
        tick();
        chk("bp_rel_src2", 32'(out_src), 32'h2);

        // Mode switch keeps ptr: explicit select of channel 0, then round-robin resumes after 0.
        mode = 1'b0;
        sel  = 2'd0;
        tick();
        chk("sw_m0_src", 32'(out_src), 32'h0);
        mode = 1'b1;
        tick();
        chk("sw_rr_src", 32'(out_src), 32'h1);

`ifdef MUX_ARB_N_LOCK_EN
        // Lock pins channel 0 for four grants, then rotation resumes.
        do_reset();
        lock = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lock_src", 32'(out_src), 32'h0);
        end
        lock = 1'b0;
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("unlock_src", 32'(out_src), 32'(k));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
